// File: rtl/vp_pkg.sv
// Shared encodings and constants for the vp_pixel_pipe slice.
// Sideband bits sit directly above the pixel in each FIFO word.
package vp_pkg;

    typedef enum logic [1:0] {
        VP_MODE_PASS   = 2'd0,
        VP_MODE_GRAY   = 2'd1,
        VP_MODE_THRESH = 2'd2,
        VP_MODE_INV    = 2'd3
    } vp_mode_e;

    // gray = (R + (G << 1) + B) >> 2
    localparam int unsigned VP_GRAY_G_SHL = 1;
    localparam int unsigned VP_GRAY_SHIFT = 2;

    function automatic int unsigned vp_eol_bit(int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned vp_eof_bit(int unsigned dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/vp_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO with fill count.
// Simultaneous push and pop are honoured at any fill, including full.
module vp_fwft_fifo #(
    parameter int unsigned W  = 14,
    parameter int unsigned AW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [W-1:0]  o_rdata,
    output logic          o_full,
    output logic [AW:0]   o_fill
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   fill_q;
    logic          do_push, do_pop;

    always_comb begin
        o_valid = (fill_q != '0);
        o_full  = (fill_q == (AW+1)'(DEPTH));
        o_fill  = fill_q;
        do_pop  = i_pop && o_valid;
        do_push = i_push && (!o_full || do_pop);
        o_rdata = o_valid ? mem_q[rd_q] : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   fill_q <= fill_q + (AW+1)'(1);
                2'b01:   fill_q <= fill_q - (AW+1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q] <= i_wdata;
    end

    // Upstream credits must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst) !(i_push && o_full));

endmodule

// File: rtl/vp_pixel_pipe.sv
// Pixel front end: 2-stage mode pipe, raster tracking, credit-gated FWFT FIFO.
// Optional statistics outputs are enabled by defining VP_STATS_EN.
module vp_pixel_pipe
    import vp_pkg::*;
#(
    parameter int unsigned DW   = 12,
    parameter int unsigned CH   = 3,
    parameter int unsigned RL   = 640,
    parameter int unsigned ROWS = 480,
    parameter int unsigned FAW  = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_mode,
    input  logic [DW/CH-1:0] i_thresh,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    input  logic [DW-1:0]    i_data,
    input  logic             i_data_ready,
    output logic             o_data_valid,
    output logic [DW-1:0]    o_data,
    output logic             o_eol,
    output logic             o_eof
`ifdef VP_STATS_EN
   ,output logic [15:0]      o_frame_cnt,
    output logic [15:0]      o_stall_cnt
`endif
);
    localparam int unsigned CW    = DW / CH;
    localparam int unsigned FW    = DW + 2;
    localparam int unsigned DEPTH = 1 << FAW;
    localparam int unsigned OW    = FAW + 2;
    localparam int unsigned CLW   = (RL > 1) ? $clog2(RL) : 1;
    localparam int unsigned RWW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned EOL_B = vp_eol_bit(DW);
    localparam int unsigned EOF_B = vp_eof_bit(DW);

    logic           ready_q;
    logic [CLW-1:0] col_q;
    logic [RWW-1:0] row_q;
    vp_mode_e       mode_q;
    logic [CW-1:0]  thr_q;

    logic           s1_v_q, s1_eol_q, s1_eof_q;
    logic [DW-1:0]  s1_pix_q;
    vp_mode_e       s1_mode_q;
    logic [CW-1:0]  s1_thr_q;
    logic           s2_v_q;
    logic [FW-1:0]  s2_word_q;

    logic           accept, sof, eol, eof, ready_d, pop;
    vp_mode_e       mode_eff;
    logic [CW-1:0]  thr_eff, gray;
    logic [DW-1:0]  result;
    logic [OW-1:0]  occ_nx;
    logic [FW-1:0]  fifo_rdata;
    logic [FAW:0]   fifo_fill;
    logic           fifo_full;

    always_comb begin
        accept   = i_data_valid && ready_q;
        sof      = (col_q == '0) && (row_q == '0);
        eol      = (col_q == CLW'(RL - 1));
        eof      = eol && (row_q == RWW'(ROWS - 1));
        mode_eff = sof ? vp_mode_e'(i_mode) : mode_q;
        thr_eff  = sof ? i_thresh : thr_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ready_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            mode_q  <= VP_MODE_PASS;
            thr_q   <= '0;
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            s1_v_q  <= accept;
            s2_v_q  <= s1_v_q;
            if (accept) begin
                if (sof) begin
                    mode_q <= mode_eff;
                    thr_q  <= thr_eff;
                end
                if (eol) begin
                    col_q <= '0;
                    row_q <= eof ? '0 : row_q + RWW'(1);
                end else begin
                    col_q <= col_q + CLW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            s1_pix_q  <= i_data;
            s1_eol_q  <= eol;
            s1_eof_q  <= eof;
            s1_mode_q <= mode_eff;
            s1_thr_q  <= thr_eff;
        end
        if (s1_v_q) s2_word_q <= {s1_eof_q, s1_eol_q, result};
    end

    if (CH == 3) begin : g_rgb
        logic [CW+1:0] sum;
        always_comb begin
            sum  = (CW+2)'(s1_pix_q[3*CW-1 -: CW])
                 + ((CW+2)'(s1_pix_q[2*CW-1 -: CW]) << VP_GRAY_G_SHL)
                 + (CW+2)'(s1_pix_q[CW-1:0]);
            gray = CW'(sum >> VP_GRAY_SHIFT);
        end
    end else begin : g_mono
        assign gray = s1_pix_q[CW-1:0];
    end

    always_comb begin
        result = s1_pix_q;
        case (s1_mode_q)
            VP_MODE_PASS:   result = s1_pix_q;
            VP_MODE_GRAY:   result = {CH{gray}};
            VP_MODE_THRESH: result = (gray >= s1_thr_q) ? '1 : '0;
            VP_MODE_INV:    result = ~s1_pix_q;
            default:        result = s1_pix_q;
        endcase
    end

    // Ready is registered, so it must already cover the beat it will admit:
    // it only rises when next-cycle fill plus in-flight leaves a free slot.
    always_comb begin
        pop     = o_data_valid && i_data_ready;
        occ_nx  = OW'(fifo_fill) + OW'(s2_v_q) + OW'(s1_v_q) + OW'(accept) - OW'(pop);
        ready_d = (occ_nx <= OW'(DEPTH - 1));
    end

    vp_fwft_fifo #(
        .W  (FW),
        .AW (FAW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (s2_v_q),
        .i_wdata (s2_word_q),
        .i_pop   (pop),
        .o_valid (o_data_valid),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_fill  (fifo_fill)
    );

    always_comb begin
        o_data_ready = ready_q;
        o_data       = fifo_rdata[DW-1:0];
        o_eol        = fifo_rdata[EOL_B];
        o_eof        = fifo_rdata[EOF_B];
    end

`ifdef VP_STATS_EN
    logic [15:0] frame_q, stall_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_q <= '0;
            stall_q <= '0;
        end else begin
            if (pop && o_eof && frame_q != '1) frame_q <= frame_q + 16'd1;
            if (i_data_valid && !ready_q && stall_q != '1) stall_q <= stall_q + 16'd1;
        end
    end

    assign o_frame_cnt = frame_q;
    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_vp_pixel_pipe.sv
// Scoreboard bench for vp_pixel_pipe (RL=4, ROWS=2, FAW=4); checks stats when VP_STATS_EN is defined.
module tb_vp_pixel_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [1:0]  i_mode = 2'd0;
    logic [3:0]  i_thresh = 4'd0;
    logic        i_data_valid = 1'b0;
    logic        o_data_ready;
    logic [11:0] i_data = 12'h000;
    logic        i_data_ready = 1'b0;
    logic        o_data_valid;
    logic [11:0] o_data;
    logic        o_eol, o_eof;
`ifdef VP_STATS_EN
    logic [15:0] o_frame_cnt, o_stall_cnt;
`endif

    always #5 i_clk = ~i_clk;

    vp_pixel_pipe #(.DW(12), .CH(3), .RL(4), .ROWS(2), .FAW(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_mode       (i_mode),
        .i_thresh     (i_thresh),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .i_data       (i_data),
        .i_data_ready (i_data_ready),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .o_eol        (o_eol),
        .o_eof        (o_eof)
`ifdef VP_STATS_EN
       ,.o_frame_cnt  (o_frame_cnt),
        .o_stall_cnt  (o_stall_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    logic [13:0] sb_q[$];
    logic [13:0] pop_log[$];
    int cyc = 0;
    int mcol = 0, mrow = 0;
    logic [1:0] mmode = 2'd0;
    logic [3:0] mthr = 4'd0;
    int acc_cnt = 0, pop_cnt = 0, eol_pops = 0, eof_pops = 0;
    int stall_tb = 0, frame_tb = 0;
    bit lat_arm = 0, lat_acc_seen = 0, lat_val_seen = 0;
    int lat_acc = 0, lat_val = 0;

    function automatic logic [11:0] model_px(logic [1:0] m, logic [3:0] t, logic [11:0] p);
        int g;
        logic [3:0] g4;
        g  = (int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0])) / 4;
        g4 = 4'(g);
        case (m)
            2'd0:    return p;
            2'd1:    return {g4, g4, g4};
            2'd2:    return (g >= int'(t)) ? 12'hFFF : 12'h000;
            default: return ~p;
        endcase
    endfunction

    always @(posedge i_clk) cyc++;

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge i_clk) begin
        logic [13:0] exp_w, got_w;
        logic        e_eol, e_eof;
        if (i_rst) begin
            sb_q.delete();
            mcol = 0; mrow = 0; stall_tb = 0; frame_tb = 0;
        end else begin
            if (o_data_valid && i_data_ready) begin
                got_w = {o_eof, o_eol, o_data};
                pop_cnt++;
                pop_log.push_back(got_w);
                if (o_eol) eol_pops++;
                if (o_eof) begin eof_pops++; frame_tb++; end
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_underflow: got %h, expected no output", got_w);
                end else begin
                    exp_w = sb_q.pop_front();
                    if (got_w !== exp_w) begin
                        miscompares++;
                        $display("FAIL sb_data: got {eof,eol,data}=%h, expected %h", got_w, exp_w);
                    end
                end
            end
            if (lat_arm && o_data_valid && !lat_val_seen) begin
                lat_val_seen = 1; lat_val = cyc;
            end
            if (i_data_valid && !o_data_ready) stall_tb++;
            if (i_data_valid && o_data_ready) begin
                if (lat_arm && !lat_acc_seen) begin
                    lat_acc_seen = 1; lat_acc = cyc + 1;
                end
                if (mcol == 0 && mrow == 0) begin
                    mmode = i_mode; mthr = i_thresh;
                end
                e_eol = (mcol == 3);
                e_eof = e_eol && (mrow == 1);
                sb_q.push_back({e_eof, e_eol, model_px(mmode, mthr, i_data)});
                acc_cnt++;
                if (e_eol) begin mcol = 0; mrow = (mrow == 1) ? 0 : mrow + 1; end
                else mcol++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_pix(input logic [11:0] p, input logic [1:0] m, input logic [3:0] t);
        bit got = 0;
        i_data_valid = 1'b1; i_data = p; i_mode = m; i_thresh = t;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge i_clk);
            if (o_data_ready) got = 1;
            @(posedge i_clk); #1;
        end
        i_data_valid = 1'b0;
        if (!got) begin
            miscompares++;
            $display("FAIL send_timeout: o_data_ready=0, required 1 within 100 cycles");
        end
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge i_clk);
            if (sb_q.size() == 0) ok = 1;
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        @(negedge i_clk);
        vectors++;
        if ({o_data_ready, o_data_valid, o_data, o_eol, o_eof} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h eol=%b eof=%b, required all 0",
                     o_data_ready, o_data_valid, o_data, o_eol, o_eof);
        end
        @(posedge i_clk); #1; i_rst = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (o_data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_during_release: got %b, required 0", o_data_ready);
        end
        @(negedge i_clk);
        vectors++;
        if (o_data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_release: got %b, required 1", o_data_ready);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_pass();
        bit ok;
        int eol0, eof0;
        logic [13:0] e;
        pop_log.delete();
        eol0 = eol_pops; eof0 = eof_pops;
        i_data_ready = 1'b1;
        lat_acc_seen = 0; lat_val_seen = 0; lat_arm = 1;
        for (int i = 0; i < 8; i++) send_pix(12'h123 + 12'(i), 2'd0, 4'd0);
        drain(ok);
        lat_arm = 0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL pass_drain: queue=%0d, required 0", sb_q.size()); end
        vectors++;
        // Accept cycle counts as cycle 0: valid is seen two edges after the accepting edge.
        if (!(lat_acc_seen && lat_val_seen) || (lat_val - lat_acc) != 2) begin
            miscompares++;
            $display("FAIL pass_latency: got %0d edges, required 2", lat_val - lat_acc);
        end
        vectors++;
        if (eol_pops - eol0 != 2 || eof_pops - eof0 != 1) begin
            miscompares++;
            $display("FAIL pass_flags: got eol=%0d eof=%0d, required eol=2 eof=1",
                     eol_pops - eol0, eof_pops - eof0);
        end
        vectors++;
        if (pop_log.size() != 8) begin
            miscompares++;
            $display("FAIL pass_count: got %0d, required 8", pop_log.size());
        end else begin
            e = pop_log[7];
            if (e !== 14'h312A) begin
                miscompares++;
                $display("FAIL pass_last: got %h, required 312a", e);
            end
        end
    endtask

    task automatic test_gray_thresh();
        bit ok;
        logic [13:0] e;
        pop_log.delete();
        send_pix(12'hF84, 2'd1, 4'd0);
        for (int i = 1; i < 8; i++) send_pix(12'h0F0 + 12'(i), 2'd0, 4'd0);
        send_pix(12'hF84, 2'd2, 4'd8);
        send_pix(12'h321, 2'd2, 4'd8);
        for (int i = 2; i < 8; i++) send_pix(12'h888 - 12'(i), 2'd2, 4'd8);
        drain(ok);
        vectors++;
        if (!ok || pop_log.size() != 16) begin
            miscompares++;
            $display("FAIL gt_count: got %0d outputs, required 16", pop_log.size());
        end else begin
            e = pop_log[0];
            vectors++;
            if (e[11:0] !== 12'h888) begin
                miscompares++; $display("FAIL gray_F84: got %h, required 888", e[11:0]);
            end
            e = pop_log[8];
            vectors++;
            if (e[11:0] !== 12'hFFF) begin
                miscompares++; $display("FAIL thresh_F84: got %h, required fff", e[11:0]);
            end
            e = pop_log[9];
            vectors++;
            if (e[11:0] !== 12'h000) begin
                miscompares++; $display("FAIL thresh_321: got %h, required 000", e[11:0]);
            end
        end
    endtask

    task automatic test_midframe_mode();
        bit ok;
        logic [13:0] e;
        pop_log.delete();
        for (int i = 0; i < 8; i++) send_pix(12'h123 + 12'(i), (i < 2) ? 2'd0 : 2'd3, 4'd0);
        for (int i = 0; i < 8; i++) send_pix(12'h123 + 12'(i), 2'd3, 4'd0);
        drain(ok);
        vectors++;
        if (!ok || pop_log.size() != 16) begin
            miscompares++;
            $display("FAIL mid_count: got %0d outputs, required 16", pop_log.size());
        end else begin
            e = pop_log[2];
            vectors++;
            if (e[11:0] !== 12'h125) begin
                miscompares++; $display("FAIL mid_same_frame: got %h, required 125", e[11:0]);
            end
            e = pop_log[8];
            vectors++;
            if (e[11:0] !== 12'hEDC) begin
                miscompares++; $display("FAIL mid_next_frame: got %h, required edc", e[11:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok, acc_now, late_ready = 0;
        int acc0, pop0, n_acc = 0;
        acc0 = acc_cnt;
        i_data_ready = 1'b0;
        i_mode = 2'd0;
        i_data_valid = 1'b1; i_data = 12'h200;
        for (int n = 0; n < 40; n++) begin
            @(negedge i_clk);
            acc_now = o_data_ready;
            if (n_acc >= 16 && o_data_ready) late_ready = 1;
            @(posedge i_clk); #1;
            if (acc_now) begin n_acc++; i_data = i_data + 12'd1; end
        end
        i_data_valid = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (acc_cnt - acc0 != 16) begin
            miscompares++; $display("FAIL bp_accepts: got %0d, required 16", acc_cnt - acc0);
        end
        vectors++;
        if (late_ready || o_data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready_low: got ready=%b late=%b, required ready=0 late=0", o_data_ready, late_ready);
        end
`ifdef VP_STATS_EN
        vectors++;
        if (o_stall_cnt !== 16'(stall_tb)) begin
            miscompares++; $display("FAIL bp_stall_cnt: got %0d, required %0d", o_stall_cnt, stall_tb);
        end
`endif
        @(posedge i_clk); #1;
        pop0 = pop_cnt;
        i_data_ready = 1'b1;
        drain(ok);
        vectors++;
        if (!ok || pop_cnt - pop0 != 16) begin
            miscompares++; $display("FAIL bp_drain: got %0d pops, required 16", pop_cnt - pop0);
        end
`ifdef VP_STATS_EN
        @(negedge i_clk);
        vectors++;
        if (o_frame_cnt !== 16'(frame_tb)) begin
            miscompares++; $display("FAIL frame_cnt: got %0d, required %0d", o_frame_cnt, frame_tb);
        end
        @(posedge i_clk); #1;
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [13:0] e;
        i_data_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_pix(12'h400 + 12'(i), 2'd0, 4'd0);
        repeat (3) @(posedge i_clk);
        #1;
        @(negedge i_clk);
        vectors++;
        if (o_data_valid !== 1'b1) begin
            miscompares++; $display("FAIL rmid_pre_valid: got %b, required 1", o_data_valid);
        end
        @(posedge i_clk); #1; i_rst = 1'b1;
        @(posedge i_clk); #1; i_rst = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (o_data_valid !== 1'b0) begin
            miscompares++; $display("FAIL rmid_valid: got %b, required 0", o_data_valid);
        end
        @(posedge i_clk); #1;
        pop_log.delete();
        i_data_ready = 1'b1;
        send_pix(12'hF84, 2'd1, 4'd0);
        for (int i = 1; i < 8; i++) send_pix(12'h500 + 12'(i), 2'd0, 4'd0);
        drain(ok);
        vectors++;
        if (!ok || pop_log.size() != 8) begin
            miscompares++; $display("FAIL rmid_count: got %0d outputs, required 8", pop_log.size());
        end else begin
            e = pop_log[0];
            vectors++;
            if (e !== 14'h0888) begin
                miscompares++; $display("FAIL rmid_first: got %h, required 0888", e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_gray_thresh();
        test_midframe_mode();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(posedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
